vic_addr_gen: RTL and testbench

- Downstream consumer of the cycle-type sequencer.
- Converts the per-half-cycle cycle_type and sprite_cnt into the 14-bit VIC-II memory address, and classifies each access.
- Owns the 8-bit DRAM refresh counter and the eight latched sprite pointers.
- Feeds the bus/DRAM interface, plus the sprite and graphics data latches.

---
 rtl/vic_addr_gen_pkg.sv | 47 ++++
 rtl/vic_refresh_ctr.sv | 35 +++
 rtl/vic_addr_gen.sv | 139 +++++++++++++
 tb/tb_vic_addr_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vic_addr_gen_pkg.sv
// Shared cycle codes, access classes and constants for the VIC-II address generator.
// Consumed by the address mux, the refresh counter and anything downstream of the sequencer.
package vic_addr_gen_pkg;

  localparam logic [13:0] IDLE_ADDR = 14'h3FFF;
  localparam logic [7:0]  REFC_INIT = 8'hFF;

  // Per-half-cycle codes from the sequencer; L* = phi low, H* = phi high.
  typedef enum logic [3:0] {
    VIC_LP   = 4'd0,
    VIC_HPI1 = 4'd1,
    VIC_LPI2 = 4'd2,
    VIC_HS1  = 4'd3,
    VIC_LS2  = 4'd4,
    VIC_HS3  = 4'd5,
    VIC_LR   = 4'd6,
    VIC_HRC  = 4'd7,
    VIC_HGC  = 4'd8,
    VIC_LG   = 4'd9,
    VIC_HRI  = 4'd10,
    VIC_HRX  = 4'd11,
    VIC_HGI  = 4'd12,
    VIC_LI   = 4'd13,
    VIC_HI   = 4'd14,
    VIC_HPI3 = 4'd15
  } vic_cycle_e;

  typedef enum logic [2:0] {
    ACC_IDLE = 3'd0,
    ACC_PTR  = 3'd1,
    ACC_SPR  = 3'd2,
    ACC_REF  = 3'd3,
    ACC_CHR  = 3'd4,
    ACC_GFX  = 3'd5
  } vic_access_e;

  function automatic logic is_low_half(input logic [3:0] ct);
    return (ct == VIC_LP)  || (ct == VIC_LS2) || (ct == VIC_LR) ||
           (ct == VIC_LG)  || (ct == VIC_LI)  || (ct == VIC_LPI2);
  endfunction

  // In ECM the chip pulls address bits 10:9 low on graphics/idle fetches.
  function automatic logic [13:0] ecm_mask(input logic [13:0] a, input logic ecm);
    return ecm ? (a & 14'h39FF) : a;
  endfunction

endpackage

// File: rtl/vic_refresh_ctr.sv
// 8-bit DRAM refresh counter: synchronous load to REFC_INIT, decrement with 8-bit wrap.
// Load has priority over decrement.
module vic_refresh_ctr
  import vic_addr_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = REFC_INIT;
    end else if (dec) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= REFC_INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vic_addr_gen.sv
// VIC-II address generator: maps cycle_type/sprite_cnt to the registered 14-bit fetch
// address and access class, and holds the refresh counter and the eight sprite pointers.
module vic_addr_gen
  import vic_addr_gen_pkg::*;
(
  input  logic        clk_dot4x,
  input  logic        rst,
  input  logic        clk_phi,
  input  logic        phi_phase_start_1,
  input  logic        phi_phase_start_dav,
  input  logic [3:0]  cycle_type,
  input  logic [2:0]  sprite_cnt,
  input  logic [5:0]  sprite_mc,
  input  logic [9:0]  vc,
  input  logic [2:0]  rc,
  input  logic [3:0]  vm,
  input  logic [2:0]  cb,
  input  logic [7:0]  char_code,
  input  logic        bmm,
  input  logic        ecm,
  input  logic        idle,
  input  logic        refresh_reset,
  input  logic [7:0]  dbi,
  output logic [13:0] addr,
  output logic [2:0]  access,
  output logic [7:0]  sprite_ptr_out
);

  logic [7:0]  refc;
  logic [7:0]  ptr_q [8];
  logic [7:0]  ptr_d [8];
  logic [13:0] addr_q, addr_d;
  logic [2:0]  access_q, access_d;
  logic [7:0]  cur_ptr;
  logic [5:0]  mc_p1, mc_p2;
  logic [13:0] gfx_addr;

  // Decrement fires on the strobe that ends the LR half-cycle, so the address of that
  // half-cycle always shows the pre-decrement value.
  vic_refresh_ctr u_refresh_ctr (
    .clk  (clk_dot4x),
    .rst  (rst),
    .load (refresh_reset),
    .dec  (phi_phase_start_1 && (cycle_type == VIC_LR)),
    .cnt  (refc)
  );

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      ptr_d[i] = ptr_q[i];
    end
    if (phi_phase_start_dav && (cycle_type == VIC_LP)) begin
      ptr_d[sprite_cnt] = dbi;
    end
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        ptr_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        ptr_q[i] <= ptr_d[i];
      end
    end
  end

  assign cur_ptr        = ptr_q[sprite_cnt];
  assign sprite_ptr_out = cur_ptr;
  assign mc_p1          = sprite_mc + 6'd1;
  assign mc_p2          = sprite_mc + 6'd2;

  always_comb begin
    gfx_addr = {cb, char_code, rc};
    if (idle) begin
      gfx_addr = IDLE_ADDR;
    end else if (bmm) begin
      gfx_addr = {cb[2], vc, rc};
    end
  end

  always_comb begin
    addr_d   = ecm_mask(IDLE_ADDR, ecm);
    access_d = ACC_IDLE;
    case (cycle_type)
      VIC_LP: begin
        addr_d   = {vm, 7'h7F, sprite_cnt};
        access_d = ACC_PTR;
      end
      VIC_HS1: begin
        addr_d   = {cur_ptr, sprite_mc};
        access_d = ACC_SPR;
      end
      VIC_LS2: begin
        addr_d   = {cur_ptr, mc_p1};
        access_d = ACC_SPR;
      end
      VIC_HS3: begin
        addr_d   = {cur_ptr, mc_p2};
        access_d = ACC_SPR;
      end
      VIC_LR: begin
        addr_d   = {6'h3F, refc};
        access_d = ACC_REF;
      end
      VIC_HRC, VIC_HGC: begin
        addr_d   = {vm, vc};
        access_d = ACC_CHR;
      end
      VIC_LG: begin
        addr_d   = ecm_mask(gfx_addr, ecm);
        access_d = ACC_GFX;
      end
      default: begin
        addr_d   = ecm_mask(IDLE_ADDR, ecm);
        access_d = ACC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      addr_q   <= IDLE_ADDR;
      access_q <= ACC_IDLE;
    end else begin
      addr_q   <= addr_d;
      access_q <= access_d;
    end
  end

  assign addr   = addr_q;
  assign access = access_q;

  // Low-half cycle codes must only appear while phi is low.
  a_low_half_phi: assert property (@(posedge clk_dot4x) disable iff (rst)
    is_low_half(cycle_type) |-> !clk_phi);

endmodule

// File: tb/tb_vic_addr_gen.sv
// Directed bench for vic_addr_gen: each step drives one clock of inputs, queues the
// expected {access, addr} and compares it one clock later.
module tb_vic_addr_gen;
  import vic_addr_gen_pkg::*;

  logic        clk_dot4x;
  logic        rst;
  logic        clk_phi;
  logic        phi_phase_start_1;
  logic        phi_phase_start_dav;
  logic [3:0]  cycle_type;
  logic [2:0]  sprite_cnt;
  logic [5:0]  sprite_mc;
  logic [9:0]  vc;
  logic [2:0]  rc;
  logic [3:0]  vm;
  logic [2:0]  cb;
  logic [7:0]  char_code;
  logic        bmm, ecm, idle;
  logic        refresh_reset;
  logic [7:0]  dbi;
  logic [13:0] addr;
  logic [2:0]  access;
  logic [7:0]  sprite_ptr_out;

  logic [16:0] exp_q[$];
  int          total_checks;
  int          passed_checks;

  vic_addr_gen dut (
    .clk_dot4x           (clk_dot4x),
    .rst                 (rst),
    .clk_phi             (clk_phi),
    .phi_phase_start_1   (phi_phase_start_1),
    .phi_phase_start_dav (phi_phase_start_dav),
    .cycle_type          (cycle_type),
    .sprite_cnt          (sprite_cnt),
    .sprite_mc           (sprite_mc),
    .vc                  (vc),
    .rc                  (rc),
    .vm                  (vm),
    .cb                  (cb),
    .char_code           (char_code),
    .bmm                 (bmm),
    .ecm                 (ecm),
    .idle                (idle),
    .refresh_reset       (refresh_reset),
    .dbi                 (dbi),
    .addr                (addr),
    .access              (access),
    .sprite_ptr_out      (sprite_ptr_out)
  );

  // Clock / reset
  initial clk_dot4x = 1'b0;
  always #5 clk_dot4x = ~clk_dot4x;

  function automatic logic [16:0] ex(input logic [2:0] acc, input logic [13:0] a);
    return {acc, a};
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] expv);
    total_checks++;
    assert (obs === expv) passed_checks++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Driver: one clock per step; compare the registered output after the edge.
  task automatic step(input string tag, input logic [3:0] ct, input logic s1,
                      input logic dav, input logic [16:0] expv);
    logic [16:0] e;
    cycle_type          = ct;
    phi_phase_start_1   = s1;
    phi_phase_start_dav = dav;
    clk_phi = !(ct inside {VIC_LP, VIC_LS2, VIC_LR, VIC_LG, VIC_LI, VIC_LPI2});
    exp_q.push_back(expv);
    @(posedge clk_dot4x);
    #1;
    phi_phase_start_1   = 1'b0;
    phi_phase_start_dav = 1'b0;
    if (exp_q.size() == 0) begin
      total_checks++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {access, addr}, e);
    end
  endtask

  initial begin
    logic [7:0] refm;
    logic [3:0] idle_types [8];
    total_checks  = 0;
    passed_checks = 0;
    idle_types = '{VIC_HPI1, VIC_LPI2, VIC_HPI3, VIC_HRI, VIC_HRX, VIC_HGI, VIC_LI, VIC_HI};

    rst = 1'b1; clk_phi = 1'b1; phi_phase_start_1 = 1'b0; phi_phase_start_dav = 1'b0;
    cycle_type = VIC_HI; sprite_cnt = 3'd0; sprite_mc = 6'd0; vc = 10'd0; rc = 3'd0;
    vm = 4'd0; cb = 3'd0; char_code = 8'd0; bmm = 1'b0; ecm = 1'b0; idle = 1'b0;
    refresh_reset = 1'b0; dbi = 8'h00;

    // Reset held two clocks
    repeat (2) @(posedge clk_dot4x);
    #1;
    check("reset_state", {access, addr}, ex(ACC_IDLE, 14'h3FFF));
    check("reset_ptr", {9'd0, sprite_ptr_out}, 17'd0);

    // Reset wins over a decrement in the same clock
    step("rst_over_dec", VIC_LR, 1'b1, 1'b0, ex(ACC_IDLE, 14'h3FFF));
    rst = 1'b0;
    step("first_lr", VIC_LR, 1'b1, 1'b0, ex(ACC_REF, 14'h3FFF));

    // Refresh: reload then five decrements
    refresh_reset = 1'b1;
    step("refresh_reset", VIC_HI, 1'b0, 1'b0, ex(ACC_IDLE, 14'h3FFF));
    refresh_reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step("refresh_seq", VIC_LR, 1'b1, 1'b0, ex(ACC_REF, {6'h3F, 8'(8'hFF - k)}));
    end
    step("lr_no_strobe_a", VIC_LR, 1'b0, 1'b0, ex(ACC_REF, 14'h3FFA));
    step("lr_no_strobe_b", VIC_LR, 1'b0, 1'b0, ex(ACC_REF, 14'h3FFA));

    refm = 8'hFA;
    while (refm != 8'h00) begin
      step("refresh_run", VIC_LR, 1'b1, 1'b0, ex(ACC_REF, {6'h3F, refm}));
      refm = refm - 8'd1;
    end
    step("refc_zero", VIC_LR, 1'b1, 1'b0, ex(ACC_REF, 14'h3F00));
    step("refc_wrap", VIC_LR, 1'b0, 1'b0, ex(ACC_REF, 14'h3FFF));

    step("pre_coincide", VIC_LR, 1'b1, 1'b0, ex(ACC_REF, 14'h3FFF));
    refresh_reset = 1'b1;
    step("coincide", VIC_LR, 1'b1, 1'b0, ex(ACC_REF, 14'h3FFE));
    refresh_reset = 1'b0;
    step("reload_wins", VIC_LR, 1'b0, 1'b0, ex(ACC_REF, 14'h3FFF));

    // Pointer latch and sprite fetches
    vm = 4'h1; sprite_cnt = 3'd3; dbi = 8'hA5;
    step("lp_addr", VIC_LP, 1'b0, 1'b1, ex(ACC_PTR, 14'h07FB));
    check("ptr3_latched", {9'd0, sprite_ptr_out}, {9'd0, 8'hA5});
    sprite_mc = 6'd62;
    step("hs1", VIC_HS1, 1'b1, 1'b0, ex(ACC_SPR, 14'h297E));
    step("ls2", VIC_LS2, 1'b0, 1'b0, ex(ACC_SPR, 14'h297F));
    step("hs3_wrap", VIC_HS3, 1'b0, 1'b0, ex(ACC_SPR, 14'h2940));
    dbi = 8'hFF;
    step("lp_no_dav", VIC_LP, 1'b1, 1'b0, ex(ACC_PTR, 14'h07FB));
    check("ptr3_kept", {9'd0, sprite_ptr_out}, {9'd0, 8'hA5});
    sprite_cnt = 3'd4; #1;
    check("ptr4_zero", {9'd0, sprite_ptr_out}, 17'd0);
    sprite_mc = 6'd5;
    step("hs1_ptr4", VIC_HS1, 1'b0, 1'b0, ex(ACC_SPR, 14'h0005));
    sprite_mc = 6'd63;
    step("ls2_nocarry", VIC_LS2, 1'b0, 1'b0, ex(ACC_SPR, 14'h0000));
    sprite_cnt = 3'd7; dbi = 8'h3C;
    step("lp_spr7", VIC_LP, 1'b0, 1'b1, ex(ACC_PTR, 14'h07FF));
    check("ptr7_latched", {9'd0, sprite_ptr_out}, {9'd0, 8'h3C});
    sprite_cnt = 3'd3; #1;
    check("ptr3_after7", {9'd0, sprite_ptr_out}, {9'd0, 8'hA5});

    // C-accesses
    vm = 4'h2; vc = 10'h155;
    step("hrc", VIC_HRC, 1'b0, 1'b0, ex(ACC_CHR, 14'h0955));
    step("hgc", VIC_HGC, 1'b0, 1'b0, ex(ACC_CHR, 14'h0955));

    // G-accesses
    cb = 3'b010; char_code = 8'h41; rc = 3'd5;
    step("g_text", VIC_LG, 1'b0, 1'b0, ex(ACC_GFX, 14'h120D));
    ecm = 1'b1;
    step("g_text_ecm", VIC_LG, 1'b0, 1'b0, ex(ACC_GFX, 14'h100D));
    ecm = 1'b0; bmm = 1'b1; cb = 3'b100; vc = 10'h001;
    step("g_bitmap", VIC_LG, 1'b0, 1'b0, ex(ACC_GFX, 14'h200D));
    bmm = 1'b0; idle = 1'b1;
    step("g_idle", VIC_LG, 1'b0, 1'b0, ex(ACC_GFX, 14'h3FFF));
    ecm = 1'b1;
    step("g_idle_ecm", VIC_LG, 1'b0, 1'b0, ex(ACC_GFX, 14'h39FF));
    idle = 1'b0; ecm = 1'b0;

    // Idle cycle types, with strobes active to show no side effects
    sprite_cnt = 3'd3; dbi = 8'h77;
    for (int e = 0; e < 2; e++) begin
      ecm = (e == 1);
      for (int t = 0; t < 8; t++) begin
        step("idle_sweep", idle_types[t], 1'b1, 1'b1,
             ex(ACC_IDLE, (e == 1) ? 14'h39FF : 14'h3FFF));
      end
    end
    ecm = 1'b0;
    check("ptr3_after_idle", {9'd0, sprite_ptr_out}, {9'd0, 8'hA5});
    step("refc_after_idle", VIC_LR, 1'b0, 1'b0, ex(ACC_REF, 14'h3FFF));

    // Reset mid-frame loses pointers
    rst = 1'b1;
    step("rst_midframe", VIC_HS1, 1'b0, 1'b0, ex(ACC_IDLE, 14'h3FFF));
    check("ptr3_cleared", {9'd0, sprite_ptr_out}, 17'd0);
    rst = 1'b0;
    sprite_cnt = 3'd7; #1;
    check("ptr7_cleared", {9'd0, sprite_ptr_out}, 17'd0);

    // Final report
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
